// File: rtl/sifive_insight_tl_d_echo_tracker.sv
// sifive_insight_tl_d_echo_tracker
//
// Snoops TileLink A-channel requests and stores each request's echo field in
// a table indexed by source ID. D-channel response beats are counted, and the
// stored echo is presented alongside every D beat. The entry is freed on the
// last beat of the response. Duplicate-source captures and orphan responses
// are reported as registered one-cycle pulses.
//
// Optional feature macro: SIFIVE_INSIGHT_ECHO_PARITY_EN
//   defined   : each entry keeps an even-parity bit over its echo. The parity
//               is re-checked on every D beat that hits, and a mismatch pulses
//               err_parity.
//   undefined : no parity storage; err_parity is tied to 0.
//
// Ports
//   clock, reset_n          clock, asynchronous active-low reset
//   a_valid, a_ready        A handshake (observed only)
//   a_source, a_echo        A source ID and the echo value to capture
//   d_valid, d_ready        D handshake (observed only)
//   d_opcode, d_source,     D opcode, source ID and size (log2 bytes)
//   d_size
//   d_echo, d_echo_hit      echo and hit flag for the current D beat (comb)
//   d_last                  current D beat is the last of its message (comb)
//   outstanding             number of valid table entries
//   err_dup_source          pulse: capture into an entry that was still valid
//   err_orphan_d            pulse: first D beat with no matching entry
//   err_parity              pulse: stored parity mismatch on a D hit
module sifive_insight_tl_d_echo_tracker #(
    parameter int SOURCE_W  = 4,
    parameter int ECHO_W    = 8,
    parameter int SIZE_W    = 4,
    parameter int BEAT_LOG2 = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    input  logic                a_ready,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ECHO_W-1:0]   a_echo,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic [SIZE_W-1:0]   d_size,
    output logic [ECHO_W-1:0]   d_echo,
    output logic                d_echo_hit,
    output logic                d_last,
    output logic [SOURCE_W:0]   outstanding,
    output logic                err_dup_source,
    output logic                err_orphan_d,
    output logic                err_parity
);

    localparam int DEPTH = 1 << SOURCE_W;
    localparam logic [SOURCE_W:0] OUT_ONE = 1;

    // Number of D beats in a message: data-carrying opcodes span
    // 2^(size - BEAT_LOG2) beats when larger than one beat.
    function automatic logic [31:0] beats_of(input logic [2:0] op,
                                             input logic [SIZE_W-1:0] size);
        if ((op == 3'd1 || op == 3'd5) && (int'(size) > BEAT_LOG2))
            return 32'd1 << (int'(size) - BEAT_LOG2);
        return 32'd1;
    endfunction

    function automatic logic even_parity(input logic [ECHO_W-1:0] v);
        return ^v;
    endfunction

    logic [DEPTH-1:0]  valid_q;
    logic [ECHO_W-1:0] echo_mem [DEPTH];
    logic [7:0]        beat_cnt;

    logic a_fire, d_fire;
    logic hit, last_beat, release_d, same_src, inc, dec;
    logic err_dup_p1, err_orphan_p1;

    assign a_fire    = a_valid & a_ready;
    assign d_fire    = d_valid & d_ready;
    assign hit       = valid_q[d_source];
    assign last_beat = ({24'd0, beat_cnt} == (beats_of(d_opcode, d_size) - 32'd1));
    assign release_d = d_fire & last_beat & hit;
    assign same_src  = (a_source == d_source);

    // A capture into an entry being released this cycle counts as a fresh
    // allocation, so the release and capture cancel in the outstanding count.
    assign inc = a_fire & (~valid_q[a_source] | (release_d & same_src));
    assign dec = release_d;

    assign d_echo     = (d_valid & hit) ? echo_mem[d_source] : '0;
    assign d_echo_hit = d_valid & hit;
    assign d_last     = d_valid & last_beat;

    // Stage p0 -> p1: table control, beat counter and anomaly pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= '0;
            beat_cnt      <= 8'd0;
            outstanding   <= '0;
            err_dup_p1    <= 1'b0;
            err_orphan_p1 <= 1'b0;
        end else begin
            // Release is applied first so a same-cycle capture wins.
            if (release_d)
                valid_q[d_source] <= 1'b0;
            if (a_fire)
                valid_q[a_source] <= 1'b1;

            if (d_fire)
                beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;

            case ({inc, dec})
                2'b10:   outstanding <= outstanding + OUT_ONE;
                2'b01:   outstanding <= outstanding - OUT_ONE;
                default: outstanding <= outstanding;
            endcase

            err_dup_p1    <= a_fire & valid_q[a_source] & ~(release_d & same_src);
            err_orphan_p1 <= d_fire & (beat_cnt == 8'd0) & ~hit;
        end
    end

    // Echo payload is data: no reset, contents are meaningless until captured.
    always_ff @(posedge clock) begin
        if (a_fire)
            echo_mem[a_source] <= a_echo;
    end

    assign err_dup_source = err_dup_p1;
    assign err_orphan_d   = err_orphan_p1;

`ifdef SIFIVE_INSIGHT_ECHO_PARITY_EN
    logic [DEPTH-1:0] par_mem;
    logic             err_parity_p1;

    always_ff @(posedge clock) begin
        if (a_fire)
            par_mem[a_source] <= even_parity(a_echo);
    end

    // Stage p0 -> p1: parity check on D hits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            err_parity_p1 <= 1'b0;
        else
            err_parity_p1 <= d_fire & hit &
                             (even_parity(echo_mem[d_source]) != par_mem[d_source]);
    end

    assign err_parity = err_parity_p1;
`else
    assign err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_sifive_insight_tl_d_echo_tracker.sv
module tb_sifive_insight_tl_d_echo_tracker;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       a_valid, a_ready;
    logic [3:0] a_source;
    logic [7:0] a_echo;
    logic       d_valid, d_ready;
    logic [2:0] d_opcode;
    logic [3:0] d_source;
    logic [3:0] d_size;
    logic [7:0] d_echo;
    logic       d_echo_hit, d_last;
    logic [4:0] outstanding;
    logic       err_dup_source, err_orphan_d, err_parity;

    sifive_insight_tl_d_echo_tracker #(
        .SOURCE_W(4), .ECHO_W(8), .SIZE_W(4), .BEAT_LOG2(3)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_source(a_source), .a_echo(a_echo),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_source(d_source), .d_size(d_size),
        .d_echo(d_echo), .d_echo_hit(d_echo_hit), .d_last(d_last),
        .outstanding(outstanding), .err_dup_source(err_dup_source),
        .err_orphan_d(err_orphan_d), .err_parity(err_parity)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: a table of in-flight requests and the beat index of
    // the D message currently being received.
    bit       m_valid [16];
    bit [7:0] m_echo  [16];
    int       m_beat;
    bit       exp_dup, exp_orph;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int msg_beats(input int op, input int sz);
        if ((op == 1 || op == 5) && sz > 3) return 2 ** (sz - 3);
        return 1;
    endfunction

    function automatic int live_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += m_valid[i];
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_beat   = 0;
        exp_dup  = 1'b0;
        exp_orph = 1'b0;
    endtask

    task automatic drv(input bit av, input bit ar, input int as, input int ae,
                       input bit dv, input bit dr, input int op, input int ds, input int dsz);
        a_valid  = av;  a_ready = ar;
        a_source = 4'(as); a_echo = 8'(ae);
        d_valid  = dv;  d_ready = dr;
        d_opcode = 3'(op); d_source = 4'(ds); d_size = 4'(dsz);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called on a falling edge with inputs already driven: checks outputs
    // against the model, advances the model, and moves to the next falling edge.
    task automatic step();
        int  bts;
        bit  hit, last, dfire, afire, rel;
        bit [7:0] eecho;
        #1;
        bts   = msg_beats(int'(d_opcode), int'(d_size));
        hit   = d_valid && m_valid[d_source];
        last  = d_valid && (m_beat == bts - 1);
        eecho = hit ? m_echo[d_source] : 8'h00;
        check_eq("d_echo", d_echo, eecho);
        check_eq("d_echo_hit", d_echo_hit, hit);
        check_eq("d_last", d_last, last);
        check_eq("outstanding", outstanding, live_count());
        check_eq("err_dup_source", err_dup_source, exp_dup);
        check_eq("err_orphan_d", err_orphan_d, exp_orph);
        check_eq("err_parity", err_parity, 0);

        dfire    = d_valid && d_ready;
        afire    = a_valid && a_ready;
        rel      = dfire && last && hit;
        exp_orph = dfire && (m_beat == 0) && !m_valid[d_source];
        exp_dup  = afire && m_valid[a_source] && !(rel && d_source == a_source);
        if (rel) m_valid[d_source] = 1'b0;
        if (afire) begin
            m_valid[a_source] = 1'b1;
            m_echo[a_source]  = a_echo;
        end
        if (dfire) m_beat = (m_beat == bts - 1) ? 0 : m_beat + 1;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Asynchronous reset applied between edges, whatever the D stream is doing.
    task automatic mid_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_err_dup", err_dup_source, 0);
        check_eq("rst_err_orphan", err_orphan_d, 0);
        check_eq("rst_hit", d_echo_hit, 0);
        model_clear();
        idle();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int cur_op, cur_src, cur_sz;
        bit [5:0] rdy_pat;
        reset_n = 1'b0;
        idle();
        model_clear();
        repeat (2) @(negedge clock);
        #1;
        check_eq("reset_outstanding", outstanding, 0);
        check_eq("reset_err_dup", err_dup_source, 0);
        check_eq("reset_err_orphan", err_orphan_d, 0);
        check_eq("reset_err_parity", err_parity, 0);
        check_eq("reset_d_echo", d_echo, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single-beat response
        drv(1, 1, 3, 8'hA5, 0, 0, 0, 0, 0); step();
        idle(); step();
        drv(0, 0, 0, 0, 1, 1, 0, 3, 0);
        #1;
        check_eq("single_echo", d_echo, 8'hA5);
        check_eq("single_hit", d_echo_hit, 1);
        check_eq("single_last", d_last, 1);
        check_eq("single_out_before", outstanding, 1);
        step();
        idle(); step();

        // Four-beat AccessAckData with d_ready gaps
        drv(1, 1, 7, 8'h3C, 0, 0, 0, 0, 0); step();
        rdy_pat = 6'b110101;
        for (int i = 0; i < 6; i++) begin
            drv(0, 0, 0, 0, 1, rdy_pat[i], 1, 7, 5);
            #1;
            check_eq("multi_echo", d_echo, 8'h3C);
            step();
        end
        idle(); step();
        check_eq("multi_freed", outstanding, 0);

        // Duplicate source
        drv(1, 1, 2, 8'h11, 0, 0, 0, 0, 0); step();
        drv(1, 1, 2, 8'h22, 0, 0, 0, 0, 0); step();
        idle();
        #1;
        check_eq("dup_pulse", err_dup_source, 1);
        check_eq("dup_outstanding", outstanding, 1);
        step();
        drv(0, 0, 0, 0, 1, 1, 0, 2, 0);
        #1;
        check_eq("dup_new_echo", d_echo, 8'h22);
        step();
        idle(); step();

        // Orphan, then A and D on the same source in the same cycle
        drv(0, 0, 0, 0, 1, 1, 0, 5, 0);
        #1;
        check_eq("orphan_echo", d_echo, 0);
        step();
        drv(1, 1, 9, 8'h99, 1, 1, 0, 9, 0);
        #1;
        check_eq("orphan_pulse", err_orphan_d, 1);
        check_eq("same_cycle_echo", d_echo, 0);
        step();
        idle(); step();
        idle(); step();

        // Release and capture on the same source in the same cycle
        drv(1, 1, 4, 8'h01, 0, 0, 0, 0, 0); step();
        drv(1, 1, 4, 8'h77, 1, 1, 0, 4, 0); step();
        idle();
        #1;
        check_eq("swap_no_dup", err_dup_source, 0);
        step();
        drv(0, 0, 0, 0, 1, 1, 0, 4, 0);
        #1;
        check_eq("swap_echo", d_echo, 8'h77);
        step();
        idle(); step();

        // Reset during beat 2 of 4
        drv(1, 1, 1, 8'h55, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 0, 1, 1, 1, 1, 5); step();
        drv(0, 0, 0, 0, 1, 0, 1, 1, 5);
        mid_reset();
        drv(0, 0, 0, 0, 1, 1, 0, 0, 0); step();
        idle();
        #1;
        check_eq("post_reset_orphan", err_orphan_d, 1);
        step();
        drv(0, 0, 0, 0, 1, 0, 1, 1, 4);
        #1;
        check_eq("post_reset_first_beat", d_last, 0);
        step();
        idle(); step();

        // Randomized traffic over a small source range to force collisions
        cur_op = 0; cur_src = 0; cur_sz = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_beat == 0) begin
                case ($urandom_range(0, 5))
                    0: cur_op = 0;
                    1: cur_op = 1;
                    2: cur_op = 2;
                    3: cur_op = 4;
                    4: cur_op = 5;
                    default: cur_op = 6;
                endcase
                cur_src = $urandom_range(0, 3);
                cur_sz  = $urandom_range(0, 6);
            end
            drv($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 7,
                $urandom_range(0, 3), $urandom_range(0, 255),
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                cur_op, cur_src, cur_sz);
            if (i == 1500) mid_reset();
            else step();
        end
        idle(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
